decode_stage: RTL and testbench



---
 rtl/decode_stage_if.sv | 43 ++++
 rtl/decode_stage.sv | 178 +++++++++++++++++
 tb/tb_decode_stage.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch-side and uop-side handshake bundle for decode_stage.
// The slave modport is the decode stage; the master modport is fetch plus the downstream consumer.
interface decode_stage_if #(
   parameter int INSTR_W  = 8,
   parameter int REG_AW   = 3,
   parameter int ALU_OP_W = 4
);
   logic                in_valid;
   logic                in_ready;
   logic [INSTR_W-1:0]  instr;
   logic                flush;
   logic                out_valid;
   logic                out_ready;
   logic [ALU_OP_W-1:0] alu_op;
   logic [REG_AW-1:0]   rs1;
   logic [REG_AW-1:0]   rs2;
   logic [REG_AW-1:0]   rd;
   logic [3:0]          branch_addr;
   logic [1:0]          imm;
   logic                mem_read;
   logic                mem_write;
   logic                mem_write_hi;
   logic                label_read;
   logic                reg_write;
   logic                branch;
   logic                jump;
   logic                halt;
   logic                illegal;

   modport slave (
      input  in_valid, instr, flush, out_ready,
      output in_ready, out_valid, alu_op, rs1, rs2, rd, branch_addr, imm,
             mem_read, mem_write, mem_write_hi, label_read, reg_write,
             branch, jump, halt, illegal
   );

   modport master (
      output in_valid, instr, flush, out_ready,
      input  in_ready, out_valid, alu_op, rs1, rs2, rd, branch_addr, imm,
             mem_read, mem_write, mem_write_hi, label_read, reg_write,
             branch, jump, halt, illegal
   );
endinterface

// File: rtl/decode_stage.sv
// Registered valid/ready decode stage: two-beat store split, sticky halt, illegal-opcode flagging.
// Optional DECODE_STATS_EN adds saturating uop_count / stall_count outputs.
module decode_stage #(
   parameter int INSTR_W  = 8,
   parameter int REG_AW   = 3,
   parameter int ALU_OP_W = 4,
   parameter int V0_IDX   = 4,
   parameter int RC_IDX   = 5
) (
   input  logic clk,
   input  logic reset,
   decode_stage_if.slave io
`ifdef DECODE_STATS_EN
   ,
   output logic [15:0] uop_count,
   output logic [15:0] stall_count
`endif
);

   typedef struct packed {
      logic [ALU_OP_W-1:0] aluOp;
      logic [REG_AW-1:0]   rs1;
      logic [REG_AW-1:0]   rs2;
      logic [REG_AW-1:0]   rd;
      logic [3:0]          branchAddr;
      logic [1:0]          imm;
      logic                memRead;
      logic                memWrite;
      logic                memWriteHi;
      logic                labelRead;
      logic                regWrite;
      logic                branch;
      logic                jump;
      logic                halt;
      logic                illegal;
   } uopT;

   typedef enum logic [1:0] {RUN, ST2, HALTED} stateT;

   function automatic uopT decodeInstr(input logic [INSTR_W-1:0] ins);
      uopT                u;
      logic [3:0]         opc;
      logic [INSTR_W-5:0] opnd;
      logic [REG_AW-1:0]  a, b, low3;
      opc  = ins[INSTR_W-1 -: 4];
      opnd = ins[INSTR_W-5:0];
      a    = REG_AW'(opnd[3:2]);
      b    = REG_AW'(opnd[1:0]);
      low3 = REG_AW'(opnd[2:0]);
      u       = '0;
      u.aluOp = ALU_OP_W'(4'hF);
      case (opc)
         4'h0, 4'h8: begin
            u.aluOp = (opc == 4'h0) ? ALU_OP_W'(4'h0) : ALU_OP_W'(4'h2);
            u.rs1 = a; u.rs2 = b; u.rd = a; u.regWrite = 1'b1;
         end
         4'h1, 4'h4: begin
            u.aluOp = (opc == 4'h1) ? ALU_OP_W'(4'h1) : ALU_OP_W'(4'h3);
            u.rs1 = a; u.rd = a; u.imm = opnd[1:0]; u.regWrite = 1'b1;
         end
         4'h2: begin
            u.rs2 = b; u.rd = a; u.memRead = 1'b1; u.regWrite = 1'b1;
         end
         4'h3: begin
            u.rs1 = a; u.rs2 = b; u.memWrite = 1'b1;
         end
         4'h6: begin
            u.aluOp = ALU_OP_W'(4'h5); u.branchAddr = opnd[3:0];
            u.labelRead = 1'b1; u.branch = 1'b1;
         end
         4'h7: begin
            u.aluOp = ALU_OP_W'(4'hB); u.branchAddr = opnd[3:0];
            u.labelRead = 1'b1; u.jump = 1'b1;
         end
         4'h9: begin
            u.aluOp = ALU_OP_W'(4'hC); u.rs1 = low3; u.rd = REG_AW'(V0_IDX); u.regWrite = 1'b1;
         end
         4'hA: begin
            u.aluOp = ALU_OP_W'(4'hC); u.rs1 = REG_AW'(V0_IDX); u.rd = low3; u.regWrite = 1'b1;
         end
         4'hB: begin
            u.aluOp = ALU_OP_W'(4'h0); u.rs1 = a; u.rs2 = REG_AW'(RC_IDX); u.rd = a;
            u.regWrite = 1'b1;
         end
         4'hC: begin
            u.aluOp = ALU_OP_W'(4'h8); u.rs1 = low3; u.rd = low3; u.regWrite = 1'b1;
         end
         4'hD: begin
            u.aluOp = ALU_OP_W'(4'h6); u.rs1 = a; u.rs2 = b; u.rd = REG_AW'(V0_IDX);
            u.regWrite = 1'b1;
         end
         4'hE:    u.halt = 1'b1;
         default: u.illegal = 1'b1;
      endcase
      return u;
   endfunction

   stateT state;
   uopT   uop;
   uopT   dec;
   logic  outValid;
   logic  inReady;
   logic  accept;

   // Flush blocks acceptance in the same cycle so a flushed slot never loads.
   assign inReady = (state == RUN) && (!outValid || io.out_ready) && !io.flush;
   assign accept  = io.in_valid && inReady;
   assign dec     = decodeInstr(io.instr);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RUN;
         outValid <= 1'b0;
         uop      <= '0;
      end else if (io.flush) begin
         outValid <= 1'b0;
         if (state == ST2) state <= RUN;
      end else begin
         case (state)
            RUN: begin
               if (accept) begin
                  uop      <= dec;
                  outValid <= 1'b1;
                  if (dec.memWrite)  state <= ST2;
                  else if (dec.halt) state <= HALTED;
               end else if (io.out_ready) begin
                  outValid <= 1'b0;
               end
            end
            // Beat 1 is always valid here; beat 2 replaces it the cycle it is taken.
            ST2: begin
               if (io.out_ready) begin
                  uop.memWrite   <= 1'b0;
                  uop.memWriteHi <= 1'b1;
                  state          <= RUN;
               end
            end
            HALTED: begin
               if (io.out_ready) outValid <= 1'b0;
            end
            default: state <= RUN;
         endcase
      end
   end

   assign io.in_ready     = inReady;
   assign io.out_valid    = outValid;
   assign io.alu_op       = uop.aluOp;
   assign io.rs1          = uop.rs1;
   assign io.rs2          = uop.rs2;
   assign io.rd           = uop.rd;
   assign io.branch_addr  = uop.branchAddr;
   assign io.imm          = uop.imm;
   assign io.mem_read     = uop.memRead;
   assign io.mem_write    = uop.memWrite;
   assign io.mem_write_hi = uop.memWriteHi;
   assign io.label_read   = uop.labelRead;
   assign io.reg_write    = uop.regWrite;
   assign io.branch       = uop.branch;
   assign io.jump         = uop.jump;
   assign io.halt         = uop.halt;
   assign io.illegal      = uop.illegal;

`ifdef DECODE_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         uop_count   <= '0;
         stall_count <= '0;
      end else begin
         if (outValid && io.out_ready && (uop_count != 16'hFFFF))
            uop_count <= uop_count + 16'd1;
         if (io.in_valid && !inReady && (stall_count != 16'hFFFF))
            stall_count <= stall_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Directed-vector bench for decode_stage; expected uops are hand-decoded constants.
module tb_decode_stage;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

   decode_stage_if io ();
`ifdef DECODE_STATS_EN
   logic [15:0] uopCount, stallCount;
   logic [15:0] snapU, snapS;
`endif

   decode_stage dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
`ifdef DECODE_STATS_EN
      ,
      .uop_count   (uopCount),
      .stall_count (stallCount)
`endif
   );

   always #5 clk = ~clk;

   // {alu, rs1, rs2, rd, branch_addr, imm, mem_read, mem_write, mem_write_hi, label_read,
   //  reg_write, branch, jump, halt, illegal}
   logic [27:0] uopVec;
   assign uopVec = {io.alu_op, io.rs1, io.rs2, io.rd, io.branch_addr, io.imm,
                    io.mem_read, io.mem_write, io.mem_write_hi, io.label_read,
                    io.reg_write, io.branch, io.jump, io.halt, io.illegal};

   function automatic logic [27:0] mkUop(input logic [3:0] alu, input logic [2:0] r1,
                                          input logic [2:0] r2, input logic [2:0] d,
                                          input logic [3:0] ba, input logic [1:0] im,
                                          input logic [8:0] fl);
      return {alu, r1, r2, d, ba, im, fl};
   endfunction

   localparam logic [8:0] F_MRD = 9'h100, F_MWR = 9'h080, F_MWH = 9'h040, F_LBL = 9'h020,
                          F_RW = 9'h010, F_BR = 9'h008, F_J = 9'h004, F_H = 9'h002,
                          F_ILL = 9'h001;

   task automatic drive(input logic v, input logic [7:0] i, input logic r, input logic f);
      io.in_valid = v; io.instr = i; io.out_ready = r; io.flush = f;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      logic [27:0] e;
      reset = 1'b1; drive(0, 8'h00, 0, 0);
      tick(); tick();
      reset = 1'b0; #1;
      e = '0;
      checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", io.out_valid); end
      checks++; if (uopVec !== e) begin failures++; $display("FAIL reset_fields got=%h exp=%h", uopVec, e); end
      checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", io.in_ready); end
`ifdef DECODE_STATS_EN
      checks++; if ({uopCount, stallCount} !== 32'h0) begin failures++; $display("FAIL reset_stats got=%h/%h exp=0/0", uopCount, stallCount); end
`endif
   endtask

   task automatic test_back_to_back();
      logic [27:0] e;
`ifdef DECODE_STATS_EN
      snapU = uopCount;
`endif
      drive(1, 8'h06, 1, 0); #1;
      checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%0b exp=1", io.in_ready); end
      tick();
      e = mkUop(4'h0, 3'd1, 3'd2, 3'd1, 4'h0, 2'd0, F_RW);
      checks++; if ({io.out_valid, uopVec} !== {1'b1, e}) begin failures++; $display("FAIL b2b_add got=%0b/%h exp=1/%h", io.out_valid, uopVec, e); end
      drive(1, 8'h1B, 1, 0); #1;
      checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%0b exp=1", io.in_ready); end
      tick();
      e = mkUop(4'h1, 3'd2, 3'd0, 3'd2, 4'h0, 2'd3, F_RW);
      checks++; if ({io.out_valid, uopVec} !== {1'b1, e}) begin failures++; $display("FAIL b2b_addi got=%0b/%h exp=1/%h", io.out_valid, uopVec, e); end
      drive(0, 8'h00, 1, 0); tick();
      checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", io.out_valid); end
`ifdef DECODE_STATS_EN
      checks++; if (uopCount - snapU !== 16'd2) begin failures++; $display("FAIL b2b_uopcnt got=%0d exp=2", uopCount - snapU); end
`endif
   endtask

   task automatic test_store();
      logic [27:0] e;
      drive(1, 8'h36, 1, 0); tick();
      e = mkUop(4'hF, 3'd1, 3'd2, 3'd0, 4'h0, 2'd0, F_MWR);
      checks++; if ({io.out_valid, uopVec} !== {1'b1, e}) begin failures++; $display("FAIL st_beat1 got=%0b/%h exp=1/%h", io.out_valid, uopVec, e); end
      drive(1, 8'h06, 1, 0); #1;
      checks++; if (io.in_ready !== 1'b0) begin failures++; $display("FAIL st_ready_st2 got=%0b exp=0", io.in_ready); end
      tick();
      e = mkUop(4'hF, 3'd1, 3'd2, 3'd0, 4'h0, 2'd0, F_MWH);
      checks++; if ({io.out_valid, uopVec} !== {1'b1, e}) begin failures++; $display("FAIL st_beat2 got=%0b/%h exp=1/%h", io.out_valid, uopVec, e); end
      checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL st_ready_back got=%0b exp=1", io.in_ready); end
      tick();
      e = mkUop(4'h0, 3'd1, 3'd2, 3'd1, 4'h0, 2'd0, F_RW);
      checks++; if ({io.out_valid, uopVec} !== {1'b1, e}) begin failures++; $display("FAIL st_next got=%0b/%h exp=1/%h", io.out_valid, uopVec, e); end
      drive(0, 8'h00, 1, 0); tick();
   endtask

   task automatic test_stall();
      logic [27:0] e;
`ifdef DECODE_STATS_EN
      snapS = stallCount;
`endif
      drive(1, 8'h93, 0, 0); tick();
      drive(1, 8'h06, 0, 0);
      e = mkUop(4'hC, 3'd3, 3'd0, 3'd4, 4'h0, 2'd0, F_RW);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (io.in_ready !== 1'b0) begin failures++; $display("FAIL stall_ready%0d got=%0b exp=0", i, io.in_ready); end
         checks++; if ({io.out_valid, uopVec} !== {1'b1, e}) begin failures++; $display("FAIL stall_hold%0d got=%0b/%h exp=1/%h", i, io.out_valid, uopVec, e); end
         tick();
      end
      drive(1, 8'h06, 1, 0); #1;
      checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%0b exp=1", io.in_ready); end
      tick();
      e = mkUop(4'h0, 3'd1, 3'd2, 3'd1, 4'h0, 2'd0, F_RW);
      checks++; if ({io.out_valid, uopVec} !== {1'b1, e}) begin failures++; $display("FAIL stall_next got=%0b/%h exp=1/%h", io.out_valid, uopVec, e); end
      drive(0, 8'h00, 1, 0); tick();
`ifdef DECODE_STATS_EN
      checks++; if (stallCount - snapS !== 16'd3) begin failures++; $display("FAIL stall_cnt got=%0d exp=3", stallCount - snapS); end
`endif
   endtask

   task automatic test_opcodes();
      logic [7:0]  ins [9];
      logic [27:0] exp [9];
      ins[0] = 8'h2B; exp[0] = mkUop(4'hF, 3'd0, 3'd3, 3'd2, 4'h0, 2'd0, F_MRD | F_RW);
      ins[1] = 8'h47; exp[1] = mkUop(4'h3, 3'd1, 3'd0, 3'd1, 4'h0, 2'd3, F_RW);
      ins[2] = 8'h6A; exp[2] = mkUop(4'h5, 3'd0, 3'd0, 3'd0, 4'hA, 2'd0, F_LBL | F_BR);
      ins[3] = 8'h75; exp[3] = mkUop(4'hB, 3'd0, 3'd0, 3'd0, 4'h5, 2'd0, F_LBL | F_J);
      ins[4] = 8'h86; exp[4] = mkUop(4'h2, 3'd1, 3'd2, 3'd1, 4'h0, 2'd0, F_RW);
      ins[5] = 8'hA5; exp[5] = mkUop(4'hC, 3'd4, 3'd0, 3'd5, 4'h0, 2'd0, F_RW);
      ins[6] = 8'hB9; exp[6] = mkUop(4'h0, 3'd2, 3'd5, 3'd2, 4'h0, 2'd0, F_RW);
      ins[7] = 8'hCF; exp[7] = mkUop(4'h8, 3'd7, 3'd0, 3'd7, 4'h0, 2'd0, F_RW);
      ins[8] = 8'hD6; exp[8] = mkUop(4'h6, 3'd1, 3'd2, 3'd4, 4'h0, 2'd0, F_RW);
      for (int i = 0; i < 9; i++) begin
         drive(1, ins[i], 1, 0); tick();
         checks++; if ({io.out_valid, uopVec} !== {1'b1, exp[i]}) begin failures++; $display("FAIL opc_%h got=%0b/%h exp=1/%h", ins[i], io.out_valid, uopVec, exp[i]); end
      end
      drive(0, 8'h00, 1, 0); tick();
   endtask

   task automatic test_illegal();
      logic [27:0] e;
      e = mkUop(4'hF, 3'd0, 3'd0, 3'd0, 4'h0, 2'd0, F_ILL);
      drive(1, 8'h5A, 1, 0); tick();
      checks++; if ({io.out_valid, uopVec} !== {1'b1, e}) begin failures++; $display("FAIL ill_5a got=%0b/%h exp=1/%h", io.out_valid, uopVec, e); end
      drive(1, 8'hF3, 1, 0); #1;
      checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL ill_ready got=%0b exp=1", io.in_ready); end
      tick();
      checks++; if ({io.out_valid, uopVec} !== {1'b1, e}) begin failures++; $display("FAIL ill_f3 got=%0b/%h exp=1/%h", io.out_valid, uopVec, e); end
      drive(1, 8'h06, 1, 0); tick();
      e = mkUop(4'h0, 3'd1, 3'd2, 3'd1, 4'h0, 2'd0, F_RW);
      checks++; if ({io.out_valid, uopVec} !== {1'b1, e}) begin failures++; $display("FAIL ill_next got=%0b/%h exp=1/%h", io.out_valid, uopVec, e); end
      drive(0, 8'h00, 1, 0); tick();
   endtask

   task automatic test_flush();
      drive(1, 8'h36, 1, 0); tick();
`ifdef DECODE_STATS_EN
      snapU = uopCount;
`endif
      drive(1, 8'h06, 0, 1); #1;
      checks++; if (io.in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%0b exp=0", io.in_ready); end
      tick();
      checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", io.out_valid); end
      drive(0, 8'h00, 1, 0); #1;
      checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL flush_run got=%0b exp=1", io.in_ready); end
      tick();
      checks++; if ({io.out_valid, io.mem_write_hi} !== 2'b00) begin failures++; $display("FAIL flush_nobeat2 got=%b exp=00", {io.out_valid, io.mem_write_hi}); end
`ifdef DECODE_STATS_EN
      checks++; if (uopCount !== snapU) begin failures++; $display("FAIL flush_uopcnt got=%0d exp=%0d", uopCount, snapU); end
`endif
   endtask

   task automatic test_reset_st2();
      drive(1, 8'h36, 1, 0); tick();
      reset = 1'b1; drive(0, 8'h00, 1, 0); tick();
      reset = 1'b0; #1;
      checks++; if ({io.out_valid, uopVec} !== 29'h0) begin failures++; $display("FAIL rst_st2 got=%0b/%h exp=0/0", io.out_valid, uopVec); end
      tick();
      checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL rst_st2_nobeat2 got=%0b exp=0", io.out_valid); end
   endtask

   task automatic test_halt();
      logic [27:0] e;
      drive(1, 8'hE0, 1, 0); tick();
      e = mkUop(4'hF, 3'd0, 3'd0, 3'd0, 4'h0, 2'd0, F_H);
      checks++; if ({io.out_valid, uopVec} !== {1'b1, e}) begin failures++; $display("FAIL halt_uop got=%0b/%h exp=1/%h", io.out_valid, uopVec, e); end
      drive(1, 8'h00, 1, 0);
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (io.in_ready !== 1'b0) begin failures++; $display("FAIL halt_ready%0d got=%0b exp=0", i, io.in_ready); end
         tick();
      end
      checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL halt_drain got=%0b exp=0", io.out_valid); end
      drive(1, 8'h00, 1, 1); tick();
      drive(1, 8'h00, 1, 0); #1;
      checks++; if (io.in_ready !== 1'b0) begin failures++; $display("FAIL halt_flush got=%0b exp=0", io.in_ready); end
      reset = 1'b1; drive(0, 8'h00, 1, 0); tick();
      reset = 1'b0; #1;
      checks++; if ({io.in_ready, io.out_valid} !== 2'b10) begin failures++; $display("FAIL halt_reset got=%b exp=10", {io.in_ready, io.out_valid}); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_store();
      test_stall();
      test_opcodes();
      test_illegal();
      test_flush();
      test_reset_st2();
      test_halt();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
